// File: rtl/video_freeze_pkg.sv
// Shared definitions for the video freeze controller: FSM encoding and default parameters.
package video_freeze_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWaitVbl,
    StFrozen,
    StRelease
  } state_e;

  localparam int unsigned DefNreq   = 3;
  localparam int unsigned DefSettle = 2;
  localparam int unsigned DefTmoW   = 24;

endpackage

// File: rtl/edge_det.sv
// Registered rising-edge detector. Both history registers clear on reset, so no edge can be
// reported in the first cycle after reset.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= din;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/video_freeze_ctrl.sv
// Arbitrates freeze requests and times freeze engage/release to vertical lock and blanking.
module video_freeze_ctrl
  import video_freeze_pkg::*;
#(
  parameter int unsigned NREQ   = DefNreq,
  parameter int unsigned SETTLE = DefSettle,
  parameter int unsigned TMO_W  = DefTmoW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         ack,
  input  logic                    vs_in,
  input  logic                    vbl_in,
  input  logic                    lock_valid,
  output logic                    freeze,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    nolock,
  output logic                    busy
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned SW = $clog2(SETTLE + 1);

  state_e            state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              nolock_q, nolock_d;
  logic              freeze_q, freeze_d;
  logic              vs_rise, vbl_rise;
  logic              any_req;

  function automatic logic [OW-1:0] lowest_set(input logic [NREQ-1:0] v);
    logic [OW-1:0] idx;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) idx = OW'(i);
    end
    return idx;
  endfunction

  edge_det u_vs_edge (
    .clk   (clk),
    .reset (reset),
    .din   (vs_in),
    .rise  (vs_rise)
  );

  edge_det u_vbl_edge (
    .clk   (clk),
    .reset (reset),
    .din   (vbl_in),
    .rise  (vbl_rise)
  );

  assign any_req = |req;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    owner_d  = owner_q;
    nolock_d = nolock_q;
    freeze_d = freeze_q;
    ack_d    = (state_q == StFrozen) ? req : '0;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d  = StArm;
          owner_d  = lowest_set(req);
          settle_d = '0;
          tmo_d    = '0;
        end
      end
      StArm: begin
        tmo_d = tmo_q + TMO_W'(1);
        // A lock drop wins over a coincident vsync edge.
        if (!lock_valid) begin
          settle_d = '0;
        end else if (vs_rise) begin
          settle_d = settle_q + SW'(1);
        end
        if (!any_req) begin
          state_d = StIdle;
        end else if (settle_d == SW'(SETTLE)) begin
          state_d = StWaitVbl;
        end else if (&tmo_d) begin
          state_d  = StFrozen;
          freeze_d = 1'b1;
          nolock_d = 1'b1;
        end
      end
      StWaitVbl: begin
        if (!any_req) begin
          state_d = StIdle;
        end else if (vbl_rise) begin
          state_d  = StFrozen;
          freeze_d = 1'b1;
        end
      end
      StFrozen: begin
        if (!any_req) begin
          state_d = StRelease;
          tmo_d   = '0;
        end else if (!req[owner_q]) begin
          owner_d = lowest_set(req);
        end
      end
      StRelease: begin
        // Timeout only counts while both sync inputs are quiet.
        tmo_d = (vs_rise || vbl_rise) ? '0 : tmo_q + TMO_W'(1);
        if (any_req) begin
          state_d = StFrozen;
          if (!req[owner_q]) owner_d = lowest_set(req);
        end else if (vbl_rise || (&tmo_d)) begin
          state_d  = StIdle;
          freeze_d = 1'b0;
        end
      end
      default: begin
        state_d  = StIdle;
        freeze_d = 1'b0;
      end
    endcase

    if ((state_d == StIdle) && (state_q != StIdle)) begin
      nolock_d = 1'b0;
      settle_d = '0;
      tmo_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      settle_q <= '0;
      tmo_q    <= '0;
      owner_q  <= '0;
      ack_q    <= '0;
      nolock_q <= 1'b0;
      freeze_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      owner_q  <= owner_d;
      ack_q    <= ack_d;
      nolock_q <= nolock_d;
      freeze_q <= freeze_d;
    end
  end

  assign freeze = freeze_q;
  assign ack    = ack_q;
  assign owner  = owner_q;
  assign nolock = nolock_q;
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_video_freeze_ctrl.sv
// Directed scoreboard bench for video_freeze_ctrl (NREQ=3, SETTLE=2, TMO_W=8).
module tb_video_freeze_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic [2:0] ack;
  logic       vs_in;
  logic       vbl_in;
  logic       lock_valid;
  logic       freeze;
  logic [1:0] owner;
  logic       nolock;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  logic seen_high;
  logic seen_low;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t exp_q[$];

  video_freeze_ctrl #(
    .NREQ   (3),
    .SETTLE (2),
    .TMO_W  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .ack        (ack),
    .vs_in      (vs_in),
    .vbl_in     (vbl_in),
    .lock_valid (lock_valid),
    .freeze     (freeze),
    .owner      (owner),
    .nolock     (nolock),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Expected {freeze, ack, owner, nolock, busy} after the next clock edge.
  task automatic push(input string tag, input logic f, input logic [2:0] a, input logic [1:0] o,
                      input logic nl, input logic b);
    exp_t e;
    e.tag = tag;
    e.v   = {f, a, o, nl, b};
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t       e;
    logic [7:0] obs;
    @(posedge clk);
    #1;
    if (freeze) seen_high = 1'b1;
    else        seen_low  = 1'b1;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = {freeze, ack, owner, nolock, busy};
      vectors++;
      assert (obs === e.v)
      else begin
        miscompares++;
        $error("FAIL %s: observed f/ack/own/nl/busy=%b expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic check_flag(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic vs_pulse();
    vs_in = 1'b1;
    tick();
    tick();
    vs_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_to_frozen(input string tag, input logic [2:0] r, input logic [1:0] own);
    req = r;
    push({tag, "_arm"}, 1'b0, 3'b000, own, 1'b0, 1'b1);
    tick();
    vs_pulse();
    vs_pulse();
    vbl_in = 1'b1;
    push({tag, "_wait_vbl"}, 1'b0, 3'b000, own, 1'b0, 1'b1);
    tick();
    push({tag, "_freeze"}, 1'b1, 3'b000, own, 1'b0, 1'b1);
    tick();
    push({tag, "_ack"}, 1'b1, r, own, 1'b0, 1'b1);
    tick();
    vbl_in = 1'b0;
  endtask

  task automatic release_on_vbl(input string tag, input logic [1:0] own, input logic nl);
    req = 3'b000;
    push({tag, "_release"}, 1'b1, 3'b000, own, nl, 1'b1);
    tick();
    vbl_in = 1'b1;
    push({tag, "_rel_hold"}, 1'b1, 3'b000, own, nl, 1'b1);
    tick();
    push({tag, "_idle"}, 1'b0, 3'b000, own, 1'b0, 1'b0);
    tick();
    vbl_in = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    req        = 3'b000;
    vs_in      = 1'b0;
    vbl_in     = 1'b0;
    lock_valid = 1'b1;
    seen_high  = 1'b0;
    seen_low   = 1'b0;

    tick();
    push("reset_state", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;

    // Single requester through lock, settle and vblank.
    run_to_frozen("t1", 3'b001, 2'd0);

    // Drop and re-request before vblank: freeze must hold.
    seen_low = 1'b0;
    req      = 3'b000;
    push("t4_release", 1'b1, 3'b000, 2'd0, 1'b0, 1'b1);
    tick();
    req = 3'b001;
    push("t4_refrozen", 1'b1, 3'b000, 2'd0, 1'b0, 1'b1);
    tick();
    push("t4_ack", 1'b1, 3'b001, 2'd0, 1'b0, 1'b1);
    tick();
    check_flag("t4_freeze_never_low", seen_low, 1'b0);
    release_on_vbl("t4", 2'd0, 1'b0);

    // Simultaneous requests, then ownership hand-off while frozen.
    seen_low = 1'b0;
    run_to_frozen("t2", 3'b110, 2'd1);
    seen_low = 1'b0;
    req      = 3'b100;
    push("t2_owner_handoff", 1'b1, 3'b100, 2'd2, 1'b0, 1'b1);
    tick();
    req = 3'b101;
    push("t2_join", 1'b1, 3'b101, 2'd2, 1'b0, 1'b1);
    tick();
    check_flag("t2_freeze_never_low", seen_low, 1'b0);
    release_on_vbl("t2", 2'd2, 1'b0);

    // Abort in ARM after one locked frame.
    seen_high = 1'b0;
    req       = 3'b001;
    push("t5_arm", 1'b0, 3'b000, 2'd0, 1'b0, 1'b1);
    tick();
    vs_pulse();
    req = 3'b000;
    push("t5_abort_idle", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);
    tick();
    check_flag("t5_freeze_never_high", seen_high, 1'b0);

    // No lock: forced freeze after 255 ARM cycles, then quiet-sync timeout release.
    lock_valid = 1'b0;
    req        = 3'b001;
    push("t3_arm", 1'b0, 3'b000, 2'd0, 1'b0, 1'b1);
    tick();
    repeat (253) tick();
    push("t3_pre_timeout", 1'b0, 3'b000, 2'd0, 1'b0, 1'b1);
    tick();
    push("t3_forced_freeze", 1'b1, 3'b000, 2'd0, 1'b1, 1'b1);
    tick();
    push("t3_ack", 1'b1, 3'b001, 2'd0, 1'b1, 1'b1);
    tick();
    req = 3'b000;
    push("t3_release", 1'b1, 3'b000, 2'd0, 1'b1, 1'b1);
    tick();
    repeat (253) tick();
    push("t3_pre_rel_timeout", 1'b1, 3'b000, 2'd0, 1'b1, 1'b1);
    tick();
    push("t3_timeout_idle", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);
    tick();
    lock_valid = 1'b1;
    tick();

    // Reset while frozen, with the request still held.
    run_to_frozen("t6", 3'b010, 2'd1);
    reset = 1'b1;
    push("t6_reset", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);
    tick();
    push("t6_reset_hold", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    req   = 3'b000;
    push("t6_post_reset", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
